branch_update_queue: RTL

BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

---
 rtl/branch_update_queue_pkg.sv | 15 +
 rtl/branch_update_queue.sv | 122 ++++++++++++
 2 files changed

// File: rtl/branch_update_queue_pkg.sv
// branch_update_queue_pkg: shared predictor constants and the in-flight branch entry type.
package branch_update_queue_pkg;

    localparam int BUQ_PC_BITS = 32;
    localparam int BUQ_DEPTH   = 8;

    typedef struct packed {
        logic [BUQ_PC_BITS-1:0] pc;
        logic                   pred_taken;
        logic                   outcome;
        logic                   valid;
        logic                   resolved;
    } buq_entry_t;

endpackage

// File: rtl/branch_update_queue.sv
// branch_update_queue: in-order retirement of out-of-order resolved branches into predictor updates.
// Optional BUQ_STATS_EN adds saturating retirement/mispredict counters. PC_BITS must equal BUQ_PC_BITS.
module branch_update_queue
    import branch_update_queue_pkg::*;
#(
    parameter int PC_BITS  = BUQ_PC_BITS,
    parameter int DEPTH    = BUQ_DEPTH,
    parameter int TAG_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alloc_valid,
    input  logic [PC_BITS-1:0]  alloc_pc,
    input  logic                alloc_pred_taken,
    output logic                alloc_ready,
    output logic [TAG_BITS-1:0] alloc_tag,
    input  logic                resolve_valid,
    input  logic [TAG_BITS-1:0] resolve_tag,
    input  logic                resolve_taken,
    input  logic                flush,
    output logic                upd_wr_en,
    output logic [PC_BITS-1:0]  upd_pc,
    output logic                upd_taken,
    output logic                mispredict,
    output logic [TAG_BITS:0]   count
`ifdef BUQ_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
`endif
);

    localparam logic [TAG_BITS:0] FULL_CNT = (TAG_BITS+1)'(DEPTH);

    buq_entry_t          entries_q [DEPTH];
    buq_entry_t          entries_d [DEPTH];
    logic [TAG_BITS-1:0] head_q, tail_q;
    logic [TAG_BITS:0]   count_q, count_d;
    logic                upd_wr_en_q, upd_taken_q, mispredict_q;
    logic [PC_BITS-1:0]  upd_pc_q;
    logic                alloc_fire, resolve_fire, retire, head_mispred;

    assign alloc_ready  = count_q < FULL_CNT;
    assign alloc_tag    = tail_q;
    assign alloc_fire   = alloc_valid && alloc_ready && !flush;
    assign resolve_fire = resolve_valid && !flush && entries_q[resolve_tag].valid && !entries_q[resolve_tag].resolved;
    assign retire       = !flush && entries_q[head_q].valid && entries_q[head_q].resolved;
    assign head_mispred = entries_q[head_q].outcome != entries_q[head_q].pred_taken;
    assign count_d      = flush ? '0 : count_q + (TAG_BITS+1)'(alloc_fire) - (TAG_BITS+1)'(retire);

    // The tail slot is never valid while allocation is possible, so these writes cannot collide.
    always_comb begin
        entries_d = entries_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid    = 1'b0;
                entries_d[i].resolved = 1'b0;
            end
        end else begin
            if (retire) begin
                entries_d[head_q].valid    = 1'b0;
                entries_d[head_q].resolved = 1'b0;
            end
            if (resolve_fire) begin
                entries_d[resolve_tag].outcome  = resolve_taken;
                entries_d[resolve_tag].resolved = 1'b1;
            end
            if (alloc_fire)
                entries_d[tail_q] = '{pc: alloc_pc, pred_taken: alloc_pred_taken, outcome: 1'b0, valid: 1'b1, resolved: 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q    <= '{default: '0};
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            upd_wr_en_q  <= 1'b0;
            upd_pc_q     <= '0;
            upd_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            entries_q    <= entries_d;
            count_q      <= count_d;
            head_q       <= flush ? '0 : head_q + TAG_BITS'(retire);
            tail_q       <= flush ? '0 : tail_q + TAG_BITS'(alloc_fire);
            upd_wr_en_q  <= retire;
            mispredict_q <= retire && head_mispred;
            if (retire) begin
                upd_pc_q    <= entries_q[head_q].pc;
                upd_taken_q <= entries_q[head_q].outcome;
            end
        end
    end

    assign upd_wr_en  = upd_wr_en_q;
    assign upd_pc     = upd_pc_q;
    assign upd_taken  = upd_taken_q;
    assign mispredict = mispredict_q;
    assign count      = count_q;

`ifdef BUQ_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (retire && stat_br_q != '1)
                stat_br_q <= stat_br_q + 32'd1;
            if (retire && head_mispred && stat_mp_q != '1)
                stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif

endmodule
